// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART link, used by both the transmitter and the receiver.
package uart_pkg;

  localparam int TICKS_PER_BIT_DEFAULT = 30;
  localparam int DATA_BITS             = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

endpackage

// File: rtl/uart_transmitter_if.sv
// Byte-in handshake and serial-out status bundle for the UART transmitter.
interface uart_transmitter_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic                 tx;
  logic                 busy;
  logic                 tx_done;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  tx,
    input  busy,
    input  tx_done
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output tx,
    output busy,
    output tx_done
  );

endinterface

// File: rtl/uart_tx_fifo.sv
// Small byte FIFO in front of the transmitter; the head is visible combinationally on pop_data.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [DATA_BITS-1:0] push_data,
  input  logic                 pop,
  output logic [DATA_BITS-1:0] pop_data,
  output logic                 full,
  output logic                 empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic [AW:0]          r_wr_ptr;
  logic [AW:0]          r_rd_ptr;
  logic                 w_do_push;
  logic                 w_do_pop;

  // The extra MSB tells a full FIFO (MSBs differ) apart from an empty one when the indices match.
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign pop_data  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: buffers bytes in a FIFO and shifts each out LSB-first, TICKS_PER_BIT clocks per bit.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int TICKS_PER_BIT = TICKS_PER_BIT_DEFAULT,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic         clk,
  input  logic         reset,
  uart_transmitter_if.slave bus
);

  localparam int             TW        = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam logic [TW-1:0]  TICK_LAST = TW'(TICKS_PER_BIT - 1);
  localparam logic [2:0]     BIT_LAST  = 3'(DATA_BITS - 1);

  uart_tx_state_t       r_state;
  uart_tx_state_t       w_next_state;
  logic [TW-1:0]        r_tick_cnt;
  logic [2:0]           r_bit_idx;
  logic [DATA_BITS-1:0] r_shift_reg;
  logic                 r_tx;
  logic                 r_tx_done;

  logic                 w_tick_last;
  logic                 w_pop;
  logic                 w_frame_end;
  logic                 w_full;
  logic                 w_empty;
  logic [DATA_BITS-1:0] w_fifo_data;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (bus.in_valid),
    .push_data (bus.in_data),
    .pop       (w_pop),
    .pop_data  (w_fifo_data),
    .full      (w_full),
    .empty     (w_empty)
  );

  assign w_tick_last = (r_tick_cnt == TICK_LAST);
  assign bus.in_ready = !w_full;
  assign bus.tx       = r_tx;
  assign bus.tx_done  = r_tx_done;
  // tx lags the state by one clock, so busy also covers the cycle that carries the final stop clock.
  assign bus.busy     = (r_state != IDLE) || !w_empty || r_tx_done;

  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_frame_end  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_next_state = START;
        end
      end
      START: begin
        if (w_tick_last) w_next_state = DATA;
      end
      DATA: begin
        if (w_tick_last && (r_bit_idx == BIT_LAST)) w_next_state = STOP;
      end
      STOP: begin
        if (w_tick_last) begin
          w_frame_end = 1'b1;
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_next_state = START;
          end else begin
            w_next_state = IDLE;
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tick_cnt  <= '0;
      r_bit_idx   <= '0;
      r_shift_reg <= '0;
      r_tx        <= 1'b1;
      r_tx_done   <= 1'b0;
    end else begin
      r_tx_done <= w_frame_end;
      r_tx      <= (r_state == START) ? 1'b0 :
                   (r_state == DATA)  ? r_shift_reg[0] : 1'b1;
      if (w_pop) begin
        r_shift_reg <= w_fifo_data;
        r_tick_cnt  <= '0;
        r_bit_idx   <= '0;
      end else if (r_state != IDLE) begin
        r_tick_cnt <= w_tick_last ? '0 : r_tick_cnt + 1'b1;
        if ((r_state == DATA) && w_tick_last) begin
          r_shift_reg <= r_shift_reg >> 1;
          r_bit_idx   <= r_bit_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter with a bench-side 8N1 receiver decoding the tx line.
module tb_uart_transmitter;

  localparam int T = 30;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  uart_transmitter_if bus ();

  uart_transmitter #(
    .TICKS_PER_BIT (T),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int         checksRun = 0;
  int         checksPassed = 0;
  int         fallQ[$];
  int         doneQ[$];
  logic [7:0] rxQ[$];
  int         widthErrors = 0;
  int         frameErrors = 0;
  bit         rxBusy = 1'b0;
  int         rxCnt = 0;
  int         rxIdx = 0;
  logic       bitLevel = 1'b1;
  logic [7:0] rxShift = '0;

  // Receiver model: frames start on the first low sample, bits are sampled mid-period
  // and every clock of a bit must match that bit's first clock.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.tx_done === 1'b1) doneQ.push_back(cyc);
      if (reset) begin
        rxBusy = 1'b0;
      end else if (!rxBusy) begin
        if (bus.tx === 1'b0) begin
          rxBusy   = 1'b1;
          rxCnt    = 0;
          bitLevel = 1'b0;
          fallQ.push_back(cyc);
        end
      end else begin
        rxCnt++;
        if (rxCnt % T == 0) bitLevel = bus.tx;
        else if (bus.tx !== bitLevel) widthErrors++;
        if (rxCnt % T == T / 2) begin
          rxIdx = rxCnt / T;
          if (rxIdx == 0 && bus.tx !== 1'b0) frameErrors++;
          else if (rxIdx >= 1 && rxIdx <= 8) rxShift[rxIdx-1] = bus.tx;
          else if (rxIdx == 9 && bus.tx !== 1'b1) frameErrors++;
        end
        if (rxCnt == 10 * T - 1) begin
          rxQ.push_back(rxShift);
          rxBusy = 1'b0;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checksRun++;
    if (observed !== expected)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    else
      checksPassed++;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clearLog();
    fallQ.delete();
    doneQ.delete();
    rxQ.delete();
    widthErrors = 0;
    frameErrors = 0;
  endtask

  // Offers a byte and returns the index of the clock edge that accepted it; in_valid stays high.
  task automatic applyStimulus(input logic [7:0] d, output int acceptEdge);
    bit ok;
    ok = 1'b0;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4000 && !ok; i++) begin
      ok = bus.in_ready;
      tick();
    end
    acceptEdge = cyc;
    if (!ok) checkOutput("push accepted", 0, 1);
  endtask

  task automatic waitDone(input int n, input int budget, input string tag);
    int i;
    i = 0;
    while (doneQ.size() < n && i < budget) begin
      tick();
      i++;
    end
    if (doneQ.size() < n) checkOutput(tag, doneQ.size(), n);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         e1, e2, e5, e6, target;
    logic [7:0] lb[20];

    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    repeat (5) @(posedge clk);
    tick();
    checkOutput("reset tx/ready/busy/done", {bus.tx, bus.in_ready, bus.busy, bus.tx_done}, 4'b1100);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checkOutput("idle tx/ready/busy/done", {bus.tx, bus.in_ready, bus.busy, bus.tx_done}, 4'b1100);
    end

    $display("[TB] single byte 0xA5");
    clearLog();
    applyStimulus(8'hA5, e1);
    bus.in_valid = 1'b0;
    checkOutput("busy after accept", bus.busy, 1);
    waitDone(1, 400, "A5 tx_done seen");
    checkOutput("busy on tx_done clock", bus.busy, 1);
    checkOutput("tx on tx_done clock", bus.tx, 1);
    tick();
    checkOutput("busy after tx_done", bus.busy, 0);
    checkOutput("tx_done one clock", bus.tx_done, 0);
    checkOutput("A5 frames", rxQ.size(), 1);
    if (fallQ.size() >= 1 && doneQ.size() >= 1 && rxQ.size() >= 1) begin
      checkOutput("A5 start latency", fallQ[0] - e1, 2);
      checkOutput("A5 frame end", doneQ[0] - fallQ[0], 10 * T - 1);
      checkOutput("A5 data", rxQ[0], 8'hA5);
    end
    checkOutput("A5 bit widths", widthErrors, 0);
    checkOutput("A5 framing", frameErrors, 0);

    $display("[TB] back-to-back 0x00, 0xFF");
    clearLog();
    applyStimulus(8'h00, e1);
    applyStimulus(8'hFF, e2);
    bus.in_valid = 1'b0;
    checkOutput("consecutive accepts", e2 - e1, 1);
    waitDone(2, 800, "b2b tx_done seen");
    if (fallQ.size() >= 2 && doneQ.size() >= 2 && rxQ.size() >= 2) begin
      checkOutput("b2b start gap", fallQ[1] - fallQ[0], 10 * T);
      checkOutput("b2b done gap", doneQ[1] - doneQ[0], 10 * T);
      checkOutput("b2b total clocks", doneQ[1] - fallQ[0] + 1, 20 * T);
      checkOutput("b2b byte0", rxQ[0], 8'h00);
      checkOutput("b2b byte1", rxQ[1], 8'hFF);
    end
    checkOutput("b2b bit widths", widthErrors, 0);
    tick();
    checkOutput("b2b busy after", bus.busy, 0);

    $display("[TB] FIFO full");
    clearLog();
    applyStimulus(8'h01, e1);
    applyStimulus(8'h02, e2);
    applyStimulus(8'h03, e2);
    applyStimulus(8'h04, e2);
    applyStimulus(8'h05, e5);
    checkOutput("five accepts back to back", e5 - e1, 4);
    checkOutput("in_ready when full", bus.in_ready, 0);
    applyStimulus(8'h06, e6);
    bus.in_valid = 1'b0;
    if (doneQ.size() >= 1) checkOutput("sixth accept after pop", e6 - doneQ[0], 1);
    else checkOutput("first frame done before sixth accept", doneQ.size(), 1);
    waitDone(6, 2200, "full tx_done seen");
    tick();
    checkOutput("full frame count", rxQ.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < rxQ.size()) checkOutput($sformatf("full byte%0d", i), rxQ[i], i + 1);
    checkOutput("full framing", frameErrors, 0);
    checkOutput("full bit widths", widthErrors, 0);

    $display("[TB] reset mid-frame");
    clearLog();
    applyStimulus(8'h3C, e1);
    bus.in_valid = 1'b0;
    target = e1 + 2 + 4 * T + T / 3;
    while (cyc < target) tick();
    checkOutput("3C data bit3 level", bus.tx, 1);
    reset = 1'b1;
    #1;
    checkOutput("mid reset tx", bus.tx, 1);
    checkOutput("mid reset busy", bus.busy, 0);
    checkOutput("mid reset ready", bus.in_ready, 1);
    tick();
    tick();
    reset = 1'b0;
    repeat (20) tick();
    checkOutput("no tx_done after reset", doneQ.size(), 0);
    checkOutput("no frame after reset", rxQ.size(), 0);
    checkOutput("idle tx after reset", bus.tx, 1);
    clearLog();
    applyStimulus(8'h5A, e1);
    bus.in_valid = 1'b0;
    waitDone(1, 400, "5A tx_done seen");
    tick();
    checkOutput("5A frames", rxQ.size(), 1);
    if (rxQ.size() >= 1) checkOutput("5A data", rxQ[0], 8'h5A);
    if (fallQ.size() >= 1) checkOutput("5A start latency", fallQ[0] - e1, 2);

    $display("[TB] loopback");
    clearLog();
    lb[0] = 8'h00;
    lb[1] = 8'h55;
    lb[2] = 8'hAA;
    lb[3] = 8'hFF;
    for (int i = 4; i < 20; i++) lb[i] = 8'($urandom);
    for (int i = 0; i < 20; i++) applyStimulus(lb[i], e1);
    bus.in_valid = 1'b0;
    waitDone(20, 7000, "loopback tx_done seen");
    tick();
    checkOutput("loopback frames", rxQ.size(), 20);
    checkOutput("loopback done pulses", doneQ.size(), 20);
    for (int i = 0; i < 20; i++)
      if (i < rxQ.size()) checkOutput($sformatf("loopback byte%0d", i), rxQ[i], lb[i]);
    checkOutput("loopback framing", frameErrors, 0);
    checkOutput("loopback bit widths", widthErrors, 0);
    checkOutput("loopback busy after", bus.busy, 0);

    $display("%0d/%0d checks passed", checksPassed, checksRun);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serial transmitter for the team's 8N1 UART link, the transmit-side counterpart of the existing UART receiver. It accepts bytes over a valid/ready handshake into a small internal FIFO and shifts each one out LSB-first on `tx` as start bit, 8 data bits and stop bit. Each bit lasts exactly `TICKS_PER_BIT` clocks, so a receiver built on the same constant decodes the stream directly.

## Interface
- `TICKS_PER_BIT`, default 30: clocks per serial bit; must be ≥2.
- `FIFO_DEPTH`, default 4: byte entries in the input FIFO; must be a power of 2 and ≥2.
- `clk` input 1: clock, rising-edge.
- `reset` input 1: asynchronous, active-high.
- `in_data` input 8: byte to transmit.
- `in_valid` input 1: `in_data` is valid this cycle.
- `in_ready` output 1: FIFO can accept a byte (`!full`).
- `tx` output 1: serial line, idle high.
- `busy` output 1: FSM not IDLE, or FIFO non-empty.
- `tx_done` output 1: one-cycle pulse on the last clock of each stop bit.

## Operation
- Handshake:
  - A byte is pushed on any rising edge where `in_valid && in_ready`.
  - `in_data` is sampled on that edge only.
  - When `in_valid` is high and `in_ready` is low, nothing is pushed. The source must hold the byte.
- FSM states are IDLE, START, DATA and STOP.
  - **IDLE:** `tx`=1. If the FIFO is non-empty, pop the head into `shift_reg`, clear `tick_cnt` and `bit_idx`, then go to START.
  - **START:** `tx`=0 for `TICKS_PER_BIT` clocks, then go to DATA.
  - **DATA:** `tx`=`shift_reg[0]`. At `tick_cnt`==`TICKS_PER_BIT`-1:
    - shift `shift_reg` right;
    - increment `bit_idx`;
    - after `bit_idx`==7, go to STOP.
  - **STOP:** `tx`=1 for `TICKS_PER_BIT` clocks. On the last stop clock:
    - assert `tx_done`;
    - if the FIFO is non-empty, pop and go directly to START (no idle gap);
    - otherwise go to IDLE.
- Counters and widths:
  - `tick_cnt` is `$clog2(TICKS_PER_BIT)` bits and wraps to 0 at `TICKS_PER_BIT`-1.
  - `bit_idx` is 3 bits.
  - FIFO pointers are `$clog2(FIFO_DEPTH)` bits with an extra wrap bit for the full/empty decision.
- `tx` is driven from a register, so it has no combinational path from any input.
- FIFO boundary cases:
  - **Full:** `in_ready`=0. A push is rejected even if a pop happens in the same cycle.
  - **Empty:** no pop occurs.
  - **Simultaneous push and pop, not full:** both take effect, and the count is unchanged.
  - **Pointer wrap:** pointers wrap modulo `FIFO_DEPTH`, with no loss of data.
- Reset, including mid-frame:
  - `tx`=1, `tx_done`=0.
  - State IDLE, FIFO emptied.
  - Counters and `shift_reg` cleared.
  - `in_ready`=1 and `busy`=0 from the first clock after reset deasserts. Any partially sent frame is abandoned.

## Timing
- Reset values: `tx`=1, `in_ready`=1, `busy`=0, `tx_done`=0.
- Latency from an accept into an empty FIFO:
  - accept at edge N;
  - FIFO non-empty after N, and the FSM pops at edge N+1;
  - `tx` falls after edge N+2.
- Frame length: exactly 10·`TICKS_PER_BIT` clocks, measured from `tx` falling to the end of the stop bit.
  - 300 clocks at the default.
- Back-to-back frames: the next start bit begins on the clock immediately after the previous stop bit's last clock. Continuous streaming therefore has a period of 10·`TICKS_PER_BIT`.
- `tx_done` is high for exactly 1 clock per frame, aligned with the final stop-bit clock.
- `busy`:
  - rises the cycle after the first accept;
  - falls the cycle after the last `tx_done` when the FIFO is empty.

## Structure
- Shared package `uart_pkg`, also used by the receiver, holds:
  - `TICKS_PER_BIT_DEFAULT` = 30;
  - `DATA_BITS` = 8;
  - `uart_tx_state_t`, an enum with IDLE, START, DATA, STOP.
- Sub-module `uart_tx_fifo` (parameter `DEPTH`, width 8):
  - ports `push`, `push_data`, `pop`, `pop_data`, `full`, `empty`;
  - `pop_data` shows the head combinationally.
- `uart_transmitter` holds the FSM, `tick_cnt`, `bit_idx`, `shift_reg` and the `tx` register.

## Test plan
- **Reset idle.** Hold `reset` for 5 clocks, then release. Expect `tx`=1, `in_ready`=1 and `busy`=0 for 20 clocks with no input.
- **Single byte 0xA5.** Push at edge N. Expect:
  - `tx` falls after N+2;
  - data line levels 1,0,1,0,0,1,0,1, each 30 clocks wide;
  - stop bit 1 for 30 clocks, with `tx_done` on its last clock;
  - `busy` falls on the next clock.
- **Back-to-back 0x00 then 0xFF.** Push both on consecutive cycles. Expect:
  - the second start bit immediately after the first stop bit;
  - total elapsed time 600 clocks from the first falling edge;
  - two `tx_done` pulses 300 clocks apart.
- **FIFO full.** With `FIFO_DEPTH`=4, hold `in_valid` high with bytes 0x01–0x06. Expect:
  - the first byte popped, then 4 more accepted;
  - `in_ready` low until the next pop;
  - all 6 bytes transmitted in order with no duplication.
- **Reset mid-frame.** Push 0x3C and assert `reset` during data bit 3. Expect `tx`=1 immediately, `busy`=0, and no `tx_done`. A new push of 0x5A then transmits correctly.
- **Loopback.** Drive `tx` into the receiver with matching `TICKS_PER_BIT`. Send 0x00, 0x55, 0xAA, 0xFF and 16 random bytes. Expect the receiver to report identical data and `ready` once per byte.
